// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives the PLL reset, waits for a stable lock, then releases
// the SDRAM controller and core resets in order. Retries on lock timeout and tears down on lock loss.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned SDRAM_INIT     = 10000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       sdram_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [7:0] timeout_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_SDRAM_INIT,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;
    logic             locked_s1_q, locked_s2_q;
    logic             locked_s;
    logic [7:0]       relock_q, relock_d;
    logic [7:0]       timeout_q, timeout_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sdram_rst_q, sdram_rst_d;
    logic             core_rst_q, core_rst_d;
    logic             ready_q, ready_d;
    logic             term_pll, term_timeout, term_stable, term_init;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

    assign locked_s     = locked_s2_q;
    assign term_pll     = (cnt_q == CNT_W'(PLL_RST_CYCLES - 1));
    assign term_timeout = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
    assign term_stable  = (cnt_q == CNT_W'(LOCK_STABLE - 1));
    assign term_init    = (cnt_q == CNT_W'(SDRAM_INIT - 1));

    always_comb begin
        state_d   = state_q;
        relock_d  = relock_q;
        timeout_d = timeout_q;
        // soft_rst outranks lock loss and every terminal in the same cycle
        if (soft_rst) begin
            state_d = ST_PLL_RST;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (term_pll) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (term_timeout) begin
                        state_d   = ST_PLL_RST;
                        timeout_d = sat_inc(timeout_q);
                    end
                end
                ST_STABLE: begin
                    if (!locked_s)        state_d = ST_WAIT_LOCK;
                    else if (term_stable) state_d = ST_SDRAM_INIT;
                end
                ST_SDRAM_INIT: begin
                    if (!locked_s) begin
                        state_d  = ST_WAIT_LOCK;
                        relock_d = sat_inc(relock_q);
                    end else if (term_init) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d  = ST_WAIT_LOCK;
                        relock_d = sat_inc(relock_q);
                    end
                end
                default: state_d = ST_PLL_RST;
            endcase
        end

        // Held soft_rst re-enters PLL_RST, so the counter restarts every cycle
        cnt_inc = !soft_rst && (state_d == state_q);
        cnt_d   = cnt_inc ? cnt_q + CNT_W'(1) : '0;

        pll_rst_d   = 1'b0;
        sdram_rst_d = 1'b1;
        core_rst_d  = 1'b1;
        ready_d     = 1'b0;
        unique case (state_d)
            ST_PLL_RST:    pll_rst_d = 1'b1;
            ST_WAIT_LOCK,
            ST_STABLE:     ;
            ST_SDRAM_INIT: sdram_rst_d = 1'b0;
            ST_RUN: begin
                sdram_rst_d = 1'b0;
                core_rst_d  = 1'b0;
                ready_d     = 1'b1;
            end
            default:       pll_rst_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            locked_s1_q <= 1'b0;
            locked_s2_q <= 1'b0;
            relock_q    <= '0;
            timeout_q   <= '0;
            pll_rst_q   <= 1'b1;
            sdram_rst_q <= 1'b1;
            core_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            assert (!(cnt_inc && cnt_q == '1));
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            locked_s1_q <= locked;
            locked_s2_q <= locked_s1_q;
            relock_q    <= relock_d;
            timeout_q   <= timeout_d;
            pll_rst_q   <= pll_rst_d;
            sdram_rst_q <= sdram_rst_d;
            core_rst_q  <= core_rst_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sdram_rst     = sdram_rst_q;
    assign core_rst      = core_rst_q;
    assign ready         = ready_q;
    assign relock_count  = relock_q;
    assign timeout_count = timeout_q;

endmodule
